// File: rtl/lsu_rv32_if.sv
// Execute-side request/response and DCache bus of the RV32I load/store unit.
// slave = the LSU itself; master = the environment (execute stage plus DCache).
interface lsu_rv32_if #(
  parameter int ADDRW  = 32,
  parameter int WORDAW = ADDRW - 2
);
  logic              iValid;
  logic              iLoad;
  logic              iStore;
  logic [2:0]        iFunct3;
  logic [ADDRW-1:0]  iAddr;
  logic [31:0]       iWData;
  logic [4:0]        iRd;
  logic              oBusy;
  logic              oValid;
  logic [31:0]       oRData;
  logic [4:0]        oRdOut;
  logic              oMisalign;
  logic              oDMem;
  logic              oDRW;
  logic [WORDAW-1:0] oDAddr;
  logic [31:0]       oDWData;
  logic [31:0]       iDRData;
  logic              iDStall;

  modport slave (
    input  iValid, iLoad, iStore, iFunct3, iAddr, iWData, iRd, iDRData, iDStall,
    output oBusy, oValid, oRData, oRdOut, oMisalign, oDMem, oDRW, oDAddr, oDWData
  );

  modport master (
    output iValid, iLoad, iStore, iFunct3, iAddr, iWData, iRd, iDRData, iDStall,
    input  oBusy, oValid, oRData, oRdOut, oMisalign, oDMem, oDRW, oDAddr, oDWData
  );
endinterface

// File: rtl/lsu_rv32.sv
// RV32I load/store unit: byte-addressed LB..SW ops become word DCache transactions,
// sub-word stores via read-modify-write, loads lane-extracted and extended.
module lsu_rv32 #(
  parameter int ADDRW  = 32,
  parameter int WORDAW = ADDRW - 2
) (
  input logic      iCLK,
  input logic      iRST,
  lsu_rv32_if.slave bus
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] RD     = 3'd1;
  localparam logic [2:0] RDWAIT = 3'd2;
  localparam logic [2:0] RMW_RD = 3'd3;
  localparam logic [2:0] RMW_WR = 3'd4;
  localparam logic [2:0] WR     = 3'd5;

  logic [2:0]  state;
  logic [1:0]  lane;
  logic [2:0]  f3;
  logic [4:0]  rd;
  logic [31:0] wdata;
  logic        reject;
  logic [7:0]  selByte;
  logic [15:0] selHalf;
  logic [31:0] loadVal;
  logic [31:0] mergeVal;

  assign bus.oBusy = (state != IDLE);

  // Loads take priority if both op flags are set; stores accept only B/H/W.
  always_comb begin
    reject = 1'b0;
    if (bus.iLoad) begin
      case (bus.iFunct3)
        3'b000, 3'b100: reject = 1'b0;
        3'b001, 3'b101: reject = bus.iAddr[0];
        3'b010:         reject = (bus.iAddr[1:0] != 2'b00);
        default:        reject = 1'b1;
      endcase
    end else if (bus.iStore) begin
      case (bus.iFunct3)
        3'b000:  reject = 1'b0;
        3'b001:  reject = bus.iAddr[0];
        3'b010:  reject = (bus.iAddr[1:0] != 2'b00);
        default: reject = 1'b1;
      endcase
    end
  end

  always_comb begin
    selByte  = bus.iDRData[{lane, 3'b000} +: 8];
    selHalf  = bus.iDRData[{lane[1], 4'b0000} +: 16];
    mergeVal = bus.iDRData;
    case (f3)
      3'b000:  loadVal = {{24{selByte[7]}}, selByte};
      3'b001:  loadVal = {{16{selHalf[15]}}, selHalf};
      3'b100:  loadVal = {24'd0, selByte};
      3'b101:  loadVal = {16'd0, selHalf};
      default: loadVal = bus.iDRData;
    endcase
    if (f3[1:0] == 2'b00)
      mergeVal[{lane, 3'b000} +: 8] = wdata[7:0];
    else
      mergeVal[{lane[1], 4'b0000} +: 16] = wdata[15:0];
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state         <= IDLE;
      lane          <= 2'd0;
      f3            <= 3'd0;
      rd            <= 5'd0;
      wdata         <= 32'd0;
      bus.oValid    <= 1'b0;
      bus.oMisalign <= 1'b0;
      bus.oRData    <= 32'd0;
      bus.oRdOut    <= 5'd0;
      bus.oDMem     <= 1'b0;
      bus.oDRW      <= 1'b1;
      bus.oDAddr    <= '0;
      bus.oDWData   <= 32'd0;
    end else begin
      bus.oValid    <= 1'b0;
      bus.oMisalign <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.iValid) begin
            lane  <= bus.iAddr[1:0];
            f3    <= bus.iFunct3;
            rd    <= bus.iRd;
            wdata <= bus.iWData;
            if (!bus.iLoad && !bus.iStore) begin
              bus.oValid <= 1'b1;
              bus.oRData <= 32'd0;
              bus.oRdOut <= bus.iRd;
            end else if (reject) begin
              bus.oValid    <= 1'b1;
              bus.oMisalign <= 1'b1;
              bus.oRData    <= 32'd0;
              bus.oRdOut    <= bus.iRd;
            end else begin
              bus.oDMem  <= 1'b1;
              bus.oDAddr <= bus.iAddr[ADDRW-1:2];
              if (bus.iLoad) begin
                bus.oDRW <= 1'b1;
                state    <= RD;
              end else if (bus.iFunct3 == 3'b010) begin
                bus.oDRW    <= 1'b0;
                bus.oDWData <= bus.iWData;
                state       <= WR;
              end else begin
                bus.oDRW <= 1'b1;
                state    <= RMW_RD;
              end
            end
          end
        end
        RD, RMW_RD: begin
          if (!bus.iDStall) begin
            bus.oDMem <= 1'b0;
            state     <= (state == RD) ? RDWAIT : RMW_WR;
          end
        end
        RDWAIT: begin
          bus.oRData <= loadVal;
          bus.oRdOut <= rd;
          bus.oValid <= 1'b1;
          state      <= IDLE;
        end
        RMW_WR: begin
          bus.oDMem   <= 1'b1;
          bus.oDRW    <= 1'b0;
          bus.oDWData <= mergeVal;
          state       <= WR;
        end
        WR: begin
          if (!bus.iDStall) begin
            bus.oDMem  <= 1'b0;
            bus.oDRW   <= 1'b1;
            bus.oValid <= 1'b1;
            bus.oRData <= 32'd0;
            bus.oRdOut <= 5'd0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_rv32.sv
// Randomized bench for lsu_rv32: word-level reference memory predicts every completion,
// a negedge monitor pops the scoreboard whenever oValid is seen.
module tb_lsu_rv32;
  logic iCLK = 1'b0;
  logic iRST = 1'b1;
  always #5 iCLK = ~iCLK;

  lsu_rv32_if bus ();
  lsu_rv32 dut (.iCLK(iCLK), .iRST(iRST), .bus(bus));

  int cyc = 0;
  always @(posedge iCLK) cyc <= cyc + 1;

  int nChk  = 0;
  int nPass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChk++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // DCache responder; also serves as the preload port for the bench
  logic [31:0] cmem [0:127];
  logic        preWr = 1'b0;
  logic [6:0]  preAddr = 7'd0;
  logic [31:0] preDat = 32'd0;
  always @(posedge iCLK) begin
    if (preWr) cmem[preAddr] <= preDat;
    else if (bus.oDMem && !bus.iDStall) begin
      if (bus.oDRW) bus.iDRData <= cmem[bus.oDAddr[6:0]];
      else          cmem[bus.oDAddr[6:0]] <= bus.oDWData;
    end
  end

  // Reference: what memory should hold, and what each op should return
  logic [31:0] refMem [0:127];

  function automatic void model(input logic ld, input logic st, input logic [2:0] fn,
                                input logic [31:0] addr, input logic [31:0] wd,
                                output logic mis, output logic [31:0] data, output int lat);
    logic [31:0] w, mask;
    int size, sh;
    bit legal;
    mis = 1'b0; data = 32'd0; lat = 0;
    if (!ld && !st) return;
    case (fn)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    size = 0;
    endcase
    legal = (size != 0) && (ld || fn < 3);
    if (!legal) begin mis = 1'b1; return; end
    if ((addr % size) != 0) begin mis = 1'b1; return; end
    w  = refMem[addr[8:2]];
    sh = int'(addr[1:0]) * 8;
    if (ld) begin
      lat  = 2;
      data = w >> sh;
      if (size == 1) begin
        data = data & 32'hFF;
        if (fn == 3'd0 && data[7]) data = data | 32'hFFFF_FF00;
      end else if (size == 2) begin
        data = data & 32'hFFFF;
        if (fn == 3'd1 && data[15]) data = data | 32'hFFFF_0000;
      end
    end else if (size == 4) begin
      lat = 1;
      refMem[addr[8:2]] = wd;
    end else begin
      lat  = 3;
      mask = ((size == 1) ? 32'hFF : 32'hFFFF) << sh;
      refMem[addr[8:2]] = (w & ~mask) | ((wd << sh) & mask);
    end
  endfunction

  typedef struct {
    int          doneCyc;
    logic        mis;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        chkRd;
  } exp_t;
  exp_t q[$];
  exp_t mon;

  always @(negedge iCLK) begin
    if (!iRST && bus.oValid) begin
      if (q.size() == 0) chk("unexpected oValid", 32'd1, 32'd0);
      else begin
        mon = q.pop_front();
        chk("latency", cyc, mon.doneCyc);
        chk("oMisalign", {31'd0, bus.oMisalign}, {31'd0, mon.mis});
        chk("oRData", bus.oRData, mon.data);
        if (mon.chkRd) chk("oRdOut", {27'd0, bus.oRdOut}, {27'd0, mon.rd});
      end
    end
  end

  // Present one op at a negedge while the LSU is idle; returns at the negedge oValid is seen,
  // leaving iValid high so the caller can chain the next op back-to-back.
  task automatic doOp(input logic ld, input logic st, input logic [2:0] fn,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic [4:0] rd, input int stall);
    exp_t e;
    logic mis;
    logic [31:0] data;
    int lat, st_n;
    bit done;
    model(ld, st, fn, addr, wd, mis, data, lat);
    st_n = (lat > 0) ? stall : 0;
    e.doneCyc = cyc + 1 + lat + st_n;
    e.mis = mis; e.data = data; e.rd = rd; e.chkRd = ld && !mis;
    q.push_back(e);
    bus.iValid = 1'b1; bus.iLoad = ld; bus.iStore = st; bus.iFunct3 = fn;
    bus.iAddr = addr; bus.iWData = wd; bus.iRd = rd;
    done = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge iCLK);
      if (k == 0) begin
        if (lat > 0) begin
          chk("request issued", {bus.oDMem, bus.oDRW, bus.oDAddr},
              {1'b1, !(st && fn == 3'd2), addr[31:2]});
          if (st_n > 0) bus.iDStall = 1'b1;
        end else begin
          chk("no request on fault/no-op", {31'd0, bus.oDMem}, 32'd0);
        end
      end else if (k <= st_n) begin
        chk("held under stall", {bus.oDMem, bus.oBusy, bus.oDAddr}, {1'b1, 1'b1, addr[31:2]});
        if (k == st_n) bus.iDStall = 1'b0;
      end
      if (bus.oValid) done = 1'b1;
    end
    chk("completion seen", {31'd0, done}, 32'd1);
  endtask

  task automatic poke(input int idx, input logic [31:0] val);
    @(negedge iCLK);
    preWr = 1'b1; preAddr = idx[6:0]; preDat = val;
    refMem[idx] = val;
    @(negedge iCLK);
    preWr = 1'b0;
  endtask

  task automatic chkResetOutputs(input string tag);
    chk({tag, " oBusy"}, {31'd0, bus.oBusy}, 32'd0);
    chk({tag, " oValid"}, {31'd0, bus.oValid}, 32'd0);
    chk({tag, " oMisalign"}, {31'd0, bus.oMisalign}, 32'd0);
    chk({tag, " oDMem/oDRW"}, {30'd0, bus.oDMem, bus.oDRW}, 32'd1);
    chk({tag, " oDAddr"}, {2'd0, bus.oDAddr}, 32'd0);
    chk({tag, " oDWData"}, bus.oDWData, 32'd0);
    chk({tag, " oRData"}, bus.oRData, 32'd0);
    chk({tag, " oRdOut"}, {27'd0, bus.oRdOut}, 32'd0);
  endtask

  logic [31:0] rwd;
  logic [2:0]  rfn;
  logic        rld, rst;
  int          r;

  initial begin
    bus.iValid = 1'b0; bus.iLoad = 1'b0; bus.iStore = 1'b0; bus.iFunct3 = 3'd0;
    bus.iAddr = 32'd0; bus.iWData = 32'd0; bus.iRd = 5'd0; bus.iDStall = 1'b0;
    bus.iDRData = 32'd0;
    for (int i = 0; i < 128; i++) begin
      @(negedge iCLK);
      preWr = 1'b1; preAddr = i[6:0]; preDat = $urandom; refMem[i] = preDat;
    end
    @(negedge iCLK);
    preWr = 1'b0;
    chkResetOutputs("reset");
    iRST = 1'b0;

    // Lane extraction on 0x8070_F0A5
    poke(32'h100 >> 2, 32'h8070_F0A5);
    doOp(1, 0, 3'b000, 32'h100, 0, 5'd1, 0);
    doOp(1, 0, 3'b100, 32'h101, 0, 5'd2, 0);
    doOp(1, 0, 3'b001, 32'h102, 0, 5'd3, 0);
    doOp(1, 0, 3'b101, 32'h102, 0, 5'd4, 0);
    doOp(1, 0, 3'b010, 32'h100, 0, 5'd5, 0);
    bus.iValid = 1'b0;

    // Byte RMW then readback
    poke(32'h100 >> 2, 32'h1122_3344);
    doOp(0, 1, 3'b000, 32'h102, 32'hA5A5_A55A, 5'd0, 0);
    doOp(1, 0, 3'b010, 32'h100, 0, 5'd6, 0);
    bus.iValid = 1'b0;
    chk("SB merged word", cmem[32'h100 >> 2], 32'h115A_3344);

    // Misaligned SH and LW
    doOp(0, 1, 3'b001, 32'h103, 32'hFFFF_FFFF, 5'd0, 0);
    doOp(1, 0, 3'b010, 32'h102, 0, 5'd7, 0);
    bus.iValid = 1'b0;
    @(negedge iCLK);

    // Stalled LW
    doOp(1, 0, 3'b010, 32'h100, 0, 5'd8, 3);
    bus.iValid = 1'b0;

    // Back-to-back SW/LW with iValid held high
    doOp(0, 1, 3'b010, 32'h40, 32'hDEAD_BEEF, 5'd0, 0);
    doOp(1, 0, 3'b010, 32'h40, 0, 5'd9, 0);
    bus.iValid = 1'b0;

    // Reset while the SH is in its write phase
    @(negedge iCLK);
    bus.iValid = 1'b1; bus.iLoad = 1'b0; bus.iStore = 1'b1; bus.iFunct3 = 3'b001;
    bus.iAddr = 32'h102; bus.iWData = 32'h0000_BEEF; bus.iRd = 5'd0;
    @(negedge iCLK);
    @(negedge iCLK);
    chk("SH in flight before reset", {31'd0, bus.oBusy}, 32'd1);
    iRST = 1'b1; bus.iValid = 1'b0;
    @(negedge iCLK);
    chkResetOutputs("mid-op reset");
    iRST = 1'b0;
    @(negedge iCLK);
    chk("aborted SH left memory", cmem[32'h100 >> 2], refMem[32'h100 >> 2]);

    // Randomized traffic
    for (int n = 0; n < 250; n++) begin
      r = $urandom_range(0, 19);
      rld = (r >= 1 && r < 11);
      rst = (r >= 11);
      if ($urandom_range(0, 3) != 0) begin
        if (rld) begin
          case ($urandom_range(0, 4))
            0: rfn = 3'b000; 1: rfn = 3'b001; 2: rfn = 3'b010; 3: rfn = 3'b100; default: rfn = 3'b101;
          endcase
        end else rfn = 3'($urandom_range(0, 2));
      end else rfn = 3'($urandom_range(0, 7));
      rwd = $urandom;
      doOp(rld, rst, rfn, 32'($urandom_range(0, 511)), rwd, 5'($urandom_range(0, 31)),
           $urandom_range(0, 2));
      if ($urandom_range(0, 1) == 0) begin
        bus.iValid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge iCLK);
      end
    end
    bus.iValid = 1'b0;
    repeat (5) @(negedge iCLK);
    chk("scoreboard drained", q.size(), 32'd0);
    for (int i = 0; i < 128; i++) chk("final memory word", cmem[i], refMem[i]);

    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end
endmodule
